texture_sampler: RTL and testbench

Pipelined bilinear texture sampler that sits directly downstream of the texture memory. It accepts one sample request per cycle: a texture index, a fixed-point (u,v) coordinate and a tag. It drives the memory's read index and consumes the returned 2048-bit texture block. It returns a filtered RGB332 colour with the tag, in request order. A single global stall provides backpressure.

---
 rtl/texture_sampler.sv | 222 ++++++++++++++++++++++
 tb/tb_texture_sampler.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/texture_sampler.sv
// -----------------------------------------------------------------------------
// texture_sampler
//
// Pipelined bilinear texture sampler placed directly after the texture memory.
// Each cycle it can accept one request: a texture index, an unsigned 4.4
// (u,v) coordinate and an opaque tag. It returns one RGB332 colour per request,
// in request order, together with the tag. A single global enable stalls every
// stage whenever the output holds a response that the consumer has not taken.
//
// Ports
//   clk, rst_n       clock, asynchronous active-low reset
//   i_req_valid      request present
//   o_req_ready      request accepted this cycle (equals the global enable)
//   i_req_tex_idx    texture index
//   i_req_u/v        4.4 fixed-point coordinates
//   i_req_tag        tag, returned unchanged
//   o_texture_idx    memory read index (combinational)
//   i_texture_data   16x16 block of 8-bit texels, one cycle after the index
//   o_rsp_valid      response present
//   i_rsp_ready      consumer takes the response
//   o_rsp_color      filtered RGB332 texel
//   o_rsp_tag        tag of the producing request
//
// Pipeline: S1 (request regs, memory data live) -> S2 (4 texels) ->
//           S3 (horizontal lerp) -> OUT (vertical lerp + rounding).
// -----------------------------------------------------------------------------
module texture_sampler #(
    parameter int TAG_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [7:0]       i_req_tex_idx,
    input  logic [7:0]       i_req_u,
    input  logic [7:0]       i_req_v,
    input  logic [TAG_W-1:0] i_req_tag,
    output logic [7:0]       o_texture_idx,
    input  logic [2047:0]    i_texture_data,
    output logic             o_rsp_valid,
    input  logic             i_rsp_ready,
    output logic [7:0]       o_rsp_color,
    output logic [TAG_W-1:0] o_rsp_tag
);

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } rgb332_t;

    // Horizontal lerp results at full precision (channel max * 16).
    typedef struct packed {
        logic [6:0] r;
        logic [6:0] g;
        logic [5:0] b;
    } hsum_t;

    // Row r occupies bits [128r +: 128], column c within it [8c +: 8].
    function automatic rgb332_t fetch(input logic [2047:0] blk,
                                      input logic [3:0]    row,
                                      input logic [3:0]    col);
        return blk[{row, col, 3'b000} +: 8];
    endfunction

    function automatic logic [6:0] hlerp3(input logic [2:0] a,
                                          input logic [2:0] b,
                                          input logic [3:0] f);
        logic [4:0] fw;
        fw = 5'd16 - {1'b0, f};
        return ({4'b0, a} * {2'b0, fw}) + ({4'b0, b} * {3'b0, f});
    endfunction

    function automatic logic [5:0] hlerp2(input logic [1:0] a,
                                          input logic [1:0] b,
                                          input logic [3:0] f);
        logic [4:0] fw;
        fw = 5'd16 - {1'b0, f};
        return ({4'b0, a} * {1'b0, fw}) + ({4'b0, b} * {2'b0, f});
    endfunction

    // Vertical lerp, +128 rounds the /256 that removes both 4-bit weights.
    function automatic logic [2:0] vlerp3(input logic [6:0] h0,
                                          input logic [6:0] h1,
                                          input logic [3:0] f);
        logic [4:0]  fw;
        logic [10:0] sum;
        fw  = 5'd16 - {1'b0, f};
        sum = ({4'b0, h0} * {6'b0, fw}) + ({4'b0, h1} * {7'b0, f}) + 11'd128;
        return sum[10:8];
    endfunction

    function automatic logic [1:0] vlerp2(input logic [5:0] h0,
                                          input logic [5:0] h1,
                                          input logic [3:0] f);
        logic [4:0] fw;
        logic [9:0] sum;
        fw  = 5'd16 - {1'b0, f};
        sum = ({4'b0, h0} * {5'b0, fw}) + ({4'b0, h1} * {6'b0, f}) + 10'd128;
        return sum[9:8];
    endfunction

    // ---------------------------------------------------------------- enable
    logic en;
    assign en          = ~o_rsp_valid | i_rsp_ready;
    assign o_req_ready = en;

    // ---------------------------------------------------------------- S1
    logic             s1_valid;
    logic [7:0]       s1_tex_idx;
    logic [7:0]       s1_u;
    logic [7:0]       s1_v;
    logic [TAG_W-1:0] s1_tag;

    // While stalled, keep addressing the block S1 is waiting on so the memory
    // keeps presenting the same data.
    assign o_texture_idx = en ? i_req_tex_idx : s1_tex_idx;

    // ---------------------------------------------------------------- S2
    logic             s2_valid;
    rgb332_t          s2_t00, s2_t10, s2_t01, s2_t11;
    logic [3:0]       s2_fu;
    logic [3:0]       s2_fv;
    logic [TAG_W-1:0] s2_tag;

    logic [3:0] ui, vi, ui1, vi1;
    rgb332_t    t00, t10, t01, t11;

    always_comb begin
        ui  = s1_u[7:4];
        vi  = s1_v[7:4];
        // 4-bit add wraps 15 -> 0, giving repeat addressing for free.
        ui1 = ui + 4'd1;
        vi1 = vi + 4'd1;
        t00 = fetch(i_texture_data, vi,  ui);
        t10 = fetch(i_texture_data, vi,  ui1);
        t01 = fetch(i_texture_data, vi1, ui);
        t11 = fetch(i_texture_data, vi1, ui1);
    end

    // ---------------------------------------------------------------- S3
    logic             s3_valid;
    hsum_t            s3_h0, s3_h1;
    logic [3:0]       s3_fv;
    logic [TAG_W-1:0] s3_tag;

    hsum_t h0, h1;

    always_comb begin
        // NOTE: always_comb assigns every output on every path (no latch).
        h0.r = hlerp3(s2_t00.r, s2_t10.r, s2_fu);
        h0.g = hlerp3(s2_t00.g, s2_t10.g, s2_fu);
        h0.b = hlerp2(s2_t00.b, s2_t10.b, s2_fu);
        h1.r = hlerp3(s2_t01.r, s2_t11.r, s2_fu);
        h1.g = hlerp3(s2_t01.g, s2_t11.g, s2_fu);
        h1.b = hlerp2(s2_t01.b, s2_t11.b, s2_fu);
    end

    // ---------------------------------------------------------------- OUT
    rgb332_t color_next;

    always_comb begin
        color_next.r = vlerp3(s3_h0.r, s3_h1.r, s3_fv);
        color_next.g = vlerp3(s3_h0.g, s3_h1.g, s3_fv);
        color_next.b = vlerp2(s3_h0.b, s3_h1.b, s3_fv);
    end

    // ---------------------------------------------------------------- regs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid    <= 1'b0;
            s1_tex_idx  <= '0;
            s1_u        <= '0;
            s1_v        <= '0;
            s1_tag      <= '0;
            s2_valid    <= 1'b0;
            s2_t00      <= '0;
            s2_t10      <= '0;
            s2_t01      <= '0;
            s2_t11      <= '0;
            s2_fu       <= '0;
            s2_fv       <= '0;
            s2_tag      <= '0;
            s3_valid    <= 1'b0;
            s3_h0       <= '0;
            s3_h1       <= '0;
            s3_fv       <= '0;
            s3_tag      <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_color <= '0;
            o_rsp_tag   <= '0;
        end else if (en) begin
            // NOTE: non-blocking so every stage samples the pre-edge value of
            // the stage before it.
            s1_valid    <= i_req_valid;
            s1_tex_idx  <= i_req_tex_idx;
            s1_u        <= i_req_u;
            s1_v        <= i_req_v;
            s1_tag      <= i_req_tag;

            s2_valid    <= s1_valid;
            s2_t00      <= t00;
            s2_t10      <= t10;
            s2_t01      <= t01;
            s2_t11      <= t11;
            s2_fu       <= s1_u[3:0];
            s2_fv       <= s1_v[3:0];
            s2_tag      <= s1_tag;

            s3_valid    <= s2_valid;
            s3_h0       <= h0;
            s3_h1       <= h1;
            s3_fv       <= s2_fv;
            s3_tag      <= s2_tag;

            o_rsp_valid <= s3_valid;
            o_rsp_color <= color_next;
            o_rsp_tag   <= s3_tag;
        end
    end

endmodule

// File: tb/tb_texture_sampler.sv
// -----------------------------------------------------------------------------
// tb_texture_sampler
//
// Directed bench for texture_sampler. A registered memory model returns the
// block addressed by o_texture_idx one cycle later. Texel contents and the
// expected colours are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_texture_sampler;

    localparam int TAG_W = 16;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             i_req_valid;
    logic             o_req_ready;
    logic [7:0]       i_req_tex_idx;
    logic [7:0]       i_req_u;
    logic [7:0]       i_req_v;
    logic [TAG_W-1:0] i_req_tag;
    logic [7:0]       o_texture_idx;
    logic [2047:0]    i_texture_data;
    logic             o_rsp_valid;
    logic             i_rsp_ready;
    logic [7:0]       o_rsp_color;
    logic [TAG_W-1:0] o_rsp_tag;

    texture_sampler #(.TAG_W(TAG_W)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (i_req_valid),
        .o_req_ready    (o_req_ready),
        .i_req_tex_idx  (i_req_tex_idx),
        .i_req_u        (i_req_u),
        .i_req_v        (i_req_v),
        .i_req_tag      (i_req_tag),
        .o_texture_idx  (o_texture_idx),
        .i_texture_data (i_texture_data),
        .o_rsp_valid    (o_rsp_valid),
        .i_rsp_ready    (i_rsp_ready),
        .o_rsp_color    (o_rsp_color),
        .o_rsp_tag      (o_rsp_tag)
    );

    always #5 clk = ~clk;

    // Memory model: data follows the sampled index by one cycle.
    logic [2047:0] mem [256];
    initial i_texture_data = '0;
    always @(posedge clk) i_texture_data <= mem[o_texture_idx];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_texel(input int blk, input int row, input int col, input logic [7:0] val);
        mem[blk][row*128 + col*8 +: 8] = val;
    endtask

    // Single request with i_rsp_ready high; checks the 3-cycle latency.
    task automatic do_sample(input logic [7:0] idx, input logic [7:0] u, input logic [7:0] v,
                             input logic [15:0] tag, input logic [7:0] exp_c, input string nm);
        i_req_valid   = 1'b1;
        i_req_tex_idx = idx;
        i_req_u       = u;
        i_req_v       = v;
        i_req_tag     = tag;
        #1;
        check({nm, "_req_ready"}, 32'(o_req_ready), 32'd1);
        check({nm, "_tex_idx"}, 32'(o_texture_idx), 32'(idx));
        step();
        i_req_valid = 1'b0;
        step();
        check({nm, "_lat1"}, 32'(o_rsp_valid), 32'd0);
        step();
        check({nm, "_lat2"}, 32'(o_rsp_valid), 32'd0);
        step();
        check({nm, "_valid"}, 32'(o_rsp_valid), 32'd1);
        check({nm, "_color"}, 32'(o_rsp_color), 32'(exp_c));
        check({nm, "_tag"}, 32'(o_rsp_tag), 32'(tag));
        step();
        check({nm, "_drain"}, 32'(o_rsp_valid), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [7:0] bp_val [6] = '{8'h81, 8'h42, 8'h24, 8'h18, 8'h99, 8'h66};
    logic [7:0] st_val [3] = '{8'h25, 8'h5A, 8'hC7};

    initial begin
        int sent, got, hold, stall_cycles, stale;
        bit seen, stall, prev_stall;
        logic [7:0] last_idx, prev_color;
        logic [15:0] prev_tag;

        for (int i = 0; i < 256; i++) mem[i] = '0;
        set_texel(5, 3, 7, 8'hE3);              // integer sample
        set_texel(6, 0, 1, 8'hFF);              // horizontal half blend (T00=0)
        set_texel(7, 15, 15, 8'hFF);            // wrap corner
        set_texel(9, 0, 0, 8'hFF);              // fu=4, fv=12 weighting
        for (int i = 0; i < 3; i++) set_texel(1 + i, 2, 4, st_val[i]);
        for (int i = 0; i < 6; i++) set_texel(10 + i, 0, 0, bp_val[i]);

        // ------------------------------------------------ reset state
        rst_n         = 1'b0;
        i_req_valid   = 1'b0;
        i_req_tex_idx = 8'h5A;
        i_req_u       = '0;
        i_req_v       = '0;
        i_req_tag     = '0;
        i_rsp_ready   = 1'b1;
        #12;
        check("rst_valid", 32'(o_rsp_valid), 32'd0);
        check("rst_color", 32'(o_rsp_color), 32'd0);
        check("rst_tag", 32'(o_rsp_tag), 32'd0);
        check("rst_ready", 32'(o_req_ready), 32'd1);
        check("rst_tex_idx", 32'(o_texture_idx), 32'h5A);
        #2 rst_n = 1'b1;
        step();

        // ------------------------------------------------ directed samples
        do_sample(8'd5, 8'h70, 8'h30, 16'h1234, 8'hE3, "integer");
        do_sample(8'd6, 8'h08, 8'h00, 16'h0006, 8'h92, "half_blend");
        do_sample(8'd7, 8'hF8, 8'hF8, 16'h0007, 8'h49, "wrap_corner");
        do_sample(8'd9, 8'h04, 8'h0C, 16'h0009, 8'h25, "vert_weight");

        // ------------------------------------------------ streaming
        for (int i = 0; i < 3; i++) begin
            i_req_valid   = 1'b1;
            i_req_tex_idx = 8'(1 + i);
            i_req_u       = 8'h40;
            i_req_v       = 8'h20;
            i_req_tag     = 16'(16'h0100 + i);
            step();
        end
        i_req_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stream_valid", 32'(o_rsp_valid), 32'd1);
            check("stream_color", 32'(o_rsp_color), 32'(st_val[i]));
            check("stream_tag", 32'(o_rsp_tag), 32'(16'h0100 + i));
        end
        step();
        check("stream_drain", 32'(o_rsp_valid), 32'd0);

        // ------------------------------------------------ backpressure
        sent = 0; got = 0; hold = 0; stall_cycles = 0;
        seen = 0; prev_stall = 0; last_idx = '0;
        prev_color = '0; prev_tag = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (o_rsp_valid && !seen) begin
                seen = 1;
                hold = 3;
            end
            if (hold > 0) begin
                i_rsp_ready = 1'b0;
                hold--;
            end else begin
                i_rsp_ready = 1'b1;
            end
            i_req_valid   = (sent < 6);
            i_req_tex_idx = 8'(10 + sent);
            i_req_u       = 8'h00;
            i_req_v       = 8'h00;
            i_req_tag     = 16'(sent);
            #1;
            stall = o_rsp_valid && !i_rsp_ready;
            check("bp_req_ready", 32'(o_req_ready), 32'(!stall));
            if (prev_stall) begin
                check("bp_hold_color", 32'(o_rsp_color), 32'(prev_color));
                check("bp_hold_tag", 32'(o_rsp_tag), 32'(prev_tag));
            end
            if (stall) begin
                stall_cycles++;
                check("bp_tex_idx", 32'(o_texture_idx), 32'(last_idx));
            end
            if (o_rsp_valid && i_rsp_ready) begin
                check("bp_tag", 32'(o_rsp_tag), 32'(got));
                check("bp_color", 32'(o_rsp_color), 32'(bp_val[got]));
                got++;
            end
            if (i_req_valid && o_req_ready) begin
                last_idx = i_req_tex_idx;
                sent++;
            end
            prev_stall = stall;
            prev_color = o_rsp_color;
            prev_tag   = o_rsp_tag;
            step();
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        check("bp_count", 32'(got), 32'd6);
        check("bp_stall_cycles", 32'(stall_cycles), 32'd3);
        #1;
        check("bp_no_extra", 32'(o_rsp_valid), 32'd0);
        step();

        // ------------------------------------------------ reset mid-stream
        for (int i = 0; i < 4; i++) begin
            i_req_valid   = 1'b1;
            i_req_tex_idx = 8'(1 + (i % 3));
            i_req_u       = 8'h40;
            i_req_v       = 8'h20;
            i_req_tag     = 16'(16'h000A + i);
            step();
        end
        i_req_valid = 1'b0;
        check("mid_pre_valid", 32'(o_rsp_valid), 32'd1);
        check("mid_pre_color", 32'(o_rsp_color), 32'h25);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(o_rsp_valid), 32'd0);
        check("mid_rst_color", 32'(o_rsp_color), 32'd0);
        check("mid_rst_tag", 32'(o_rsp_tag), 32'd0);
        #1 rst_n = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_rsp_valid) stale++;
        end
        check("mid_no_stale", 32'(stale), 32'd0);
        do_sample(8'd5, 8'h70, 8'h30, 16'h000E, 8'hE3, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
